// File: rtl/patp_pkg.sv
// Shared PATP definitions: datapath widths, opcode values and fetch-sequencer state encodings.
package patp_pkg;

  localparam int unsigned DATA_W   = 8;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned OPCODE_W = DATA_W - ADDR_W;

  // Opcode field values held in ir[DATA_W-1 -: OPCODE_W]
  localparam logic [OPCODE_W-1:0] OP_MOVE = 3'd0;
  localparam logic [OPCODE_W-1:0] OP_ADD  = 3'd1;
  localparam logic [OPCODE_W-1:0] OP_SUB  = 3'd2;
  localparam logic [OPCODE_W-1:0] OP_BRA  = 3'd3;
  localparam logic [OPCODE_W-1:0] OP_BEQ  = 3'd4;
  localparam logic [OPCODE_W-1:0] OP_LOAD = 3'd5;
  localparam logic [OPCODE_W-1:0] OP_STOR = 3'd6;
  localparam logic [OPCODE_W-1:0] OP_HALT = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_READ  = 3'd2,
    ST_LATCH = 3'd3,
    ST_DONE  = 3'd4,
    ST_WAIT  = 3'd5
  } fetch_state_e;

  // States in which the sequencer reports itself busy
  function automatic logic is_busy_state(input fetch_state_e st);
    return (st == ST_ADDR) || (st == ST_READ) || (st == ST_LATCH) || (st == ST_DONE);
  endfunction

endpackage

// File: rtl/patp_fetch_sequencer.sv
// Fetch-phase controller of the PATP core: reads the instruction at PC into IR, bumps PC,
// then pulses fetch_done to hand control to the execute stage.
module patp_fetch_sequencer #(
  parameter int unsigned DATA_W   = patp_pkg::DATA_W,
  parameter int unsigned ADDR_W   = patp_pkg::ADDR_W,
  parameter int unsigned OPCODE_W = patp_pkg::OPCODE_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                phase_exec,
  output logic                fetch_done,
  input  logic                pc_load,
  input  logic [ADDR_W-1:0]   pc_load_val,
  output logic                mem_req,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ack,
  output logic [DATA_W-1:0]   ir,
  output logic [OPCODE_W-1:0] opcode,
  output logic [ADDR_W-1:0]   operand,
  output logic [ADDR_W-1:0]   pc,
  output logic                busy
);
  import patp_pkg::*;

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] mar_q, mar_d;
  logic [DATA_W-1:0] mbr_q, mbr_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic              mem_req_q, mem_req_d;
  logic              fetch_done_q, fetch_done_d;
  logic              busy_q, busy_d;
  logic              load_ok;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; WAIT holds until the phase flag has actually flipped to execute
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (!phase_exec) state_d = ST_ADDR;
      ST_ADDR:  state_d = ST_READ;
      ST_READ:  if (mem_ack) state_d = ST_LATCH;
      ST_LATCH: state_d = ST_DONE;
      ST_DONE:  state_d = ST_WAIT;
      ST_WAIT:  if (phase_exec) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Branch loads only land while execute owns the core, so they never meet the increment
  assign load_ok = pc_load && phase_exec && ((state_q == ST_IDLE) || (state_q == ST_WAIT));

  // Datapath and output next values
  always_comb begin
    pc_d         = pc_q;
    mar_d        = mar_q;
    mbr_d        = mbr_q;
    ir_d         = ir_q;
    mem_req_d    = 1'b0;
    fetch_done_d = 1'b0;
    busy_d       = 1'b0;

    if (load_ok) begin
      pc_d = pc_load_val;
    end

    case (state_q)
      ST_ADDR:  mar_d = pc_q;
      ST_READ:  if (mem_ack) mbr_d = mem_rdata;
      ST_LATCH: begin
        ir_d = mbr_q;
        pc_d = pc_q + ADDR_W'(1);
      end
      default: ;
    endcase

    // Outputs are registered from the upcoming state so they line up with it cycle-for-cycle
    mem_req_d    = (state_d == ST_READ);
    fetch_done_d = (state_d == ST_DONE);
    busy_d       = is_busy_state(state_d);
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q         <= RESET_PC;
      mar_q        <= '0;
      mbr_q        <= '0;
      ir_q         <= '0;
      mem_req_q    <= 1'b0;
      fetch_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      mar_q        <= mar_d;
      mbr_q        <= mbr_d;
      ir_q         <= ir_d;
      mem_req_q    <= mem_req_d;
      fetch_done_q <= fetch_done_d;
      busy_q       <= busy_d;
    end
  end

  assign fetch_done = fetch_done_q;
  assign mem_req    = mem_req_q;
  assign mem_addr   = mar_q;
  assign ir         = ir_q;
  assign opcode     = ir_q[DATA_W-1 -: OPCODE_W];
  assign operand    = ir_q[ADDR_W-1:0];
  assign pc         = pc_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_patp_fetch_sequencer.sv
// Randomized bench for patp_fetch_sequencer against a transaction-timed model of fetch/execute.
module tb_patp_fetch_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       phase_exec;
  logic       fetch_done;
  logic       pc_load;
  logic [4:0] pc_load_val;
  logic       mem_req;
  logic [4:0] mem_addr;
  logic [7:0] mem_rdata;
  logic       mem_ack;
  logic [7:0] ir;
  logic [2:0] opcode;
  logic [4:0] operand;
  logic [4:0] pc;
  logic       busy;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] mem [32];
  logic [4:0] exp_pc;
  logic [7:0] exp_ir;

  always #5 clk = ~clk;

  patp_fetch_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .phase_exec  (phase_exec),
    .fetch_done  (fetch_done),
    .pc_load     (pc_load),
    .pc_load_val (pc_load_val),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .mem_ack     (mem_ack),
    .ir          (ir),
    .opcode      (opcode),
    .operand     (operand),
    .pc          (pc),
    .busy        (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One instruction: fetch with w wait cycles, then e execute cycles with the flag high.
  // The fetch begins in the current cycle (sequencer idle, phase low); fetch_done is due
  // 4+w cycles later, mem_req spans offsets 2..2+w, busy spans offsets 1..4+w.
  // br_mode: 0 no branch, 1 random branches, 2 branch to tgt in first execute cycle.
  task automatic fetch_one(input int w, input int e, input int br_mode,
                           input logic [4:0] tgt, input bit abort);
    logic [4:0] addr;
    bit         last;
    addr = exp_pc;
    for (int j = 0; j <= 4 + w; j++) begin
      last = (j == 4 + w);
      chk("busy", 32'(busy), 32'(j >= 1));
      chk("mem_req", 32'(mem_req), 32'(j >= 2 && j <= 2 + w));
      if (j >= 2 && j <= 2 + w) chk("mem_addr", 32'(mem_addr), 32'(addr));
      chk("fetch_done", 32'(fetch_done), 32'(last));
      if (last) begin
        exp_pc = addr + 5'd1;
        exp_ir = mem[addr];
      end
      chk("pc", 32'(pc), 32'(exp_pc));
      chk("ir", 32'(ir), 32'(exp_ir));
      if (last) begin
        chk("opcode", 32'(opcode), 32'(exp_ir >> 5));
        chk("operand", 32'(operand), 32'(exp_ir & 8'h1f));
      end
      if (abort && j == 2) begin
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_pc", 32'(pc), 32'd0);
        chk("rst_ir", 32'(ir), 32'd0);
        exp_pc     = 5'd0;
        exp_ir     = 8'd0;
        phase_exec = 1'b0;
        mem_ack    = 1'b0;
        pc_load    = 1'b0;
        step();
        chk("rst_hold_mem_req", 32'(mem_req), 32'd0);
        chk("rst_hold_done", 32'(fetch_done), 32'd0);
        rst_n = 1'b1;
        return;
      end
      phase_exec  = 1'b0;
      pc_load     = 1'($urandom_range(0, 1));
      pc_load_val = 5'($urandom);
      if (j == 2 + w) begin
        mem_ack   = 1'b1;
        mem_rdata = mem[addr];
      end else if (j >= 2 && j < 2 + w) begin
        mem_ack   = 1'b0;
        mem_rdata = 8'($urandom);
      end else begin
        mem_ack   = 1'($urandom_range(0, 1));
        mem_rdata = 8'($urandom);
      end
      step();
    end
    for (int i = 1; i <= e; i++) begin
      chk("x_busy", 32'(busy), 32'd0);
      chk("x_mem_req", 32'(mem_req), 32'd0);
      chk("x_fetch_done", 32'(fetch_done), 32'd0);
      chk("x_pc", 32'(pc), 32'(exp_pc));
      chk("x_ir", 32'(ir), 32'(exp_ir));
      phase_exec  = 1'b1;
      mem_ack     = 1'($urandom_range(0, 1));
      mem_rdata   = 8'($urandom);
      pc_load_val = 5'($urandom);
      case (br_mode)
        1:       pc_load = ($urandom_range(0, 2) == 0);
        2: begin
          pc_load     = (i == 1);
          pc_load_val = tgt;
        end
        default: pc_load = 1'b0;
      endcase
      if (pc_load) exp_pc = pc_load_val;
      step();
    end
  endtask

  initial begin
    for (int k = 0; k < 32; k++) mem[k] = 8'($urandom);
    mem[0]      = 8'hA3;
    rst_n       = 1'b0;
    phase_exec  = 1'b0;
    pc_load     = 1'b0;
    pc_load_val = 5'd0;
    mem_ack     = 1'b0;
    mem_rdata   = 8'd0;
    exp_pc      = 5'd0;
    exp_ir      = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_pc", 32'(pc), 32'd0);
    chk("reset_ir", 32'(ir), 32'd0);
    chk("reset_mem_req", 32'(mem_req), 32'd0);
    chk("reset_mem_addr", 32'(mem_addr), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_fetch_done", 32'(fetch_done), 32'd0);
    rst_n = 1'b1;

    // Zero-wait fetch of 8'hA3 at address 0
    fetch_one(0, 2, 0, 5'd0, 1'b0);
    chk("a3_ir", 32'(ir), 32'h0A3);
    chk("a3_opcode", 32'(opcode), 32'd5);
    chk("a3_operand", 32'(operand), 32'h03);
    chk("a3_pc", 32'(pc), 32'd1);

    // Three wait states, then branch to 5'h12 and fetch from there
    fetch_one(3, 2, 2, 5'h12, 1'b0);
    chk("branch_pc", 32'(pc), 32'h12);
    fetch_one(1, 3, 0, 5'd0, 1'b0);

    // Wrap: branch to 31, fetch 31 (pc -> 0), then fetch address 0
    fetch_one(0, 2, 2, 5'd31, 1'b0);
    fetch_one(0, 1, 0, 5'd0, 1'b0);
    chk("wrap_pc", 32'(pc), 32'd0);
    fetch_one(2, 2, 0, 5'd0, 1'b0);

    // Reset in the middle of a long read
    fetch_one(5, 2, 0, 5'd0, 1'b1);

    // Back-to-back handshake with execute clearing the flag after 2 cycles
    for (int n = 0; n < 10; n++) fetch_one(0, 2, 0, 5'd0, 1'b0);

    // Randomized mix of wait states, execute lengths, branches and resets
    for (int n = 0; n < 200; n++)
      fetch_one(int'($urandom_range(0, 4)), int'($urandom_range(1, 4)), 1, 5'd0,
                ($urandom_range(0, 15) == 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
